// File: rtl/lr35902_dma_pkg.sv
// Shared definitions for the LR35902 DMA engines (HBlank/general VRAM DMA and OAM DMA).
package lr35902_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_COPY    = 2'd2,
        ST_WAIT_HB = 2'd3
    } dma_state_t;

    localparam logic [2:0] HDMA1_IDX = 3'd0;
    localparam logic [2:0] HDMA2_IDX = 3'd1;
    localparam logic [2:0] HDMA3_IDX = 3'd2;
    localparam logic [2:0] HDMA4_IDX = 3'd3;
    localparam logic [2:0] HDMA5_IDX = 3'd4;

    localparam int HDMA5_MODE_BIT = 7;

    // OAM DMA block: fixed 160-byte copy into FE00, triggered through FF46.
    localparam int          OAM_DMA_BYTES   = 160;
    localparam logic [15:0] OAM_DMA_DEST    = 16'hFE00;
    localparam logic [15:0] OAM_DMA_REG_ADR = 16'hFF46;

    function automatic logic owns_bus(input dma_state_t s);
        return (s == ST_SETUP) || (s == ST_COPY);
    endfunction

endpackage

// File: rtl/lr35902_hdma_if.sv
// Register, PPU and memory-bus signals of the VRAM DMA controller.
interface lr35902_hdma_if;
    import lr35902_dma_pkg::*;

    // Register writes are single strobes committed on the falling edge of reg_write;
    // read/write are plain bus strobes with no back-pressure (memory always accepts).
    logic [2:0]  reg_adr;
    logic [7:0]  reg_din;
    logic        reg_write;
    logic [7:0]  reg_dout;
    logic        hblank;
    logic        lcd_on;
    logic [15:0] adr;
    logic [12:0] adr_vram;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        read;
    logic        write;
    logic        active;
    dma_state_t  dbg_state;

    modport master (
        input  reg_adr, reg_din, reg_write, hblank, lcd_on, din,
        output reg_dout, adr, adr_vram, dout, read, write, active, dbg_state
    );

    modport slave (
        output reg_adr, reg_din, reg_write, hblank, lcd_on, din,
        input  reg_dout, adr, adr_vram, dout, read, write, active, dbg_state
    );

endinterface

// File: rtl/lr35902_dma_byte_timer.sv
// Per-byte cycle counter: strobe for the first STROBE_CYCLES cycles, byte_done on the last.
module lr35902_dma_byte_timer #(
    parameter int BYTE_CYCLES   = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic strobe,
    output logic byte_done
);

    localparam int CW = $clog2(BYTE_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(BYTE_CYCLES - 1);

    logic [CW-1:0] cyc;

    // Held at zero while idle so each run starts on a fresh byte.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cyc <= '0;
        end else if (cyc == CYC_LAST) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    assign strobe    = run && (int'(cyc) < STROBE_CYCLES);
    assign byte_done = run && (cyc == CYC_LAST);

endmodule

// File: rtl/lr35902_hdma.sv
// VRAM DMA controller: general (CPU halted) and HBlank (one block per HBlank) copy modes.
module lr35902_hdma
    import lr35902_dma_pkg::*;
#(
    parameter int BLOCK_BYTES   = 16,
    parameter int BYTE_CYCLES   = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int SETUP_CYCLES  = 2
) (
    input logic clk,
    input logic reset,
    lr35902_hdma_if.master bus
);

    localparam int BW = $clog2(BLOCK_BYTES);
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [BW-1:0] BYTE_LAST  = BW'(BLOCK_BYTES - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

    dma_state_t  state, state_nxt;
    logic        reg_write_q, hblank_q;
    logic [15:0] src;
    logic [12:0] dst;
    logic [6:0]  remaining;
    logic        mode_hb, cancel_pend, first_blk;
    logic [BW-1:0] byte_cnt;
    logic [SW-1:0] setup_cnt;
    logic        strobe, byte_done;
    logic        xfer, own;

    logic commit, wr_hdma5, stop_req, addr_wr_ok, hb_rise;
    logic setup_done, block_done, last_block, cancel_now;

    assign commit     = reg_write_q && !bus.reg_write;
    assign wr_hdma5   = commit && (bus.reg_adr == HDMA5_IDX);
    assign stop_req   = wr_hdma5 && !bus.reg_din[HDMA5_MODE_BIT];
    assign addr_wr_ok = commit && ((state == ST_IDLE) || (state == ST_WAIT_HB));
    assign hb_rise    = bus.hblank && !hblank_q;
    assign setup_done = (state == ST_SETUP) && (setup_cnt == SETUP_LAST);
    assign block_done = byte_done && (byte_cnt == BYTE_LAST);
    assign last_block = (remaining == 7'd0);
    // A stop landing on the very cycle the block ends must still take effect.
    assign cancel_now = cancel_pend || (stop_req && mode_hb);

    lr35902_dma_byte_timer #(
        .BYTE_CYCLES  (BYTE_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_byte_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (state == ST_COPY),
        .strobe   (strobe),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wr_hdma5) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (setup_done) begin
                    if (mode_hb && first_blk && !(bus.hblank || !bus.lcd_on)) begin
                        state_nxt = ST_WAIT_HB;
                    end else begin
                        state_nxt = ST_COPY;
                    end
                end
            end
            ST_COPY: begin
                if (block_done) begin
                    if (last_block)      state_nxt = ST_IDLE;
                    else if (!mode_hb)   state_nxt = ST_COPY;
                    else if (cancel_now) state_nxt = ST_IDLE;
                    else                 state_nxt = ST_WAIT_HB;
                end
            end
            ST_WAIT_HB: begin
                if (stop_req)                     state_nxt = ST_IDLE;
                else if (hb_rise && bus.lcd_on)   state_nxt = ST_SETUP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        own  = owns_bus(state);
        xfer = 1'b0;
        if (state == ST_COPY) xfer = strobe;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            hblank_q    <= 1'b0;
            src         <= 16'h0000;
            dst         <= 13'h0000;
            remaining   <= 7'h7F;
            mode_hb     <= 1'b0;
            cancel_pend <= 1'b0;
            first_blk   <= 1'b0;
            byte_cnt    <= '0;
            setup_cnt   <= '0;
        end else begin
            reg_write_q <= bus.reg_write;
            hblank_q    <= bus.hblank;

            if (state != ST_SETUP || setup_done) setup_cnt <= '0;
            else                                 setup_cnt <= setup_cnt + 1'b1;

            if (state != ST_COPY) byte_cnt <= '0;
            else if (byte_done)   byte_cnt <= byte_cnt + 1'b1;

            // Address registers are only writable while the engine is off the bus.
            if (addr_wr_ok) begin
                case (bus.reg_adr)
                    HDMA1_IDX: src[15:8] <= bus.reg_din;
                    HDMA2_IDX: src[7:0]  <= {bus.reg_din[7:4], 4'h0};
                    HDMA3_IDX: dst[12:8] <= bus.reg_din[4:0];
                    HDMA4_IDX: dst[7:0]  <= {bus.reg_din[7:4], 4'h0};
                    default: ;
                endcase
            end else if (byte_done) begin
                src <= src + 16'd1;
                dst <= dst + 13'd1;
            end

            if (state == ST_IDLE && wr_hdma5) begin
                remaining   <= bus.reg_din[6:0];
                mode_hb     <= bus.reg_din[HDMA5_MODE_BIT];
                cancel_pend <= 1'b0;
                first_blk   <= 1'b1;
            end
            if (state == ST_COPY && block_done) remaining <= remaining - 7'd1;
            if (state == ST_COPY && stop_req && mode_hb) cancel_pend <= 1'b1;
            if (setup_done) first_blk <= 1'b0;
        end
    end

    always_comb begin
        bus.reg_dout = 8'hFF;
        if (bus.reg_adr == HDMA5_IDX) bus.reg_dout = {state == ST_IDLE, remaining};
    end

    assign bus.active    = own;
    assign bus.read      = xfer;
    assign bus.write     = xfer;
    assign bus.adr       = src;
    assign bus.adr_vram  = dst;
    assign bus.dout      = bus.din;
    assign bus.dbg_state = state;

endmodule
